spdif_subframe_assembler: RTL and testbench

- Sits directly downstream of the S/PDIF biphase-mark front end inside the receiver (`mvp`).
- Consumes the decoded bit stream and preamble markers, and assembles 28-bit subframes.
- Checks parity, pairs left (B/M) and right (W) subframes, and emits 24-bit stereo samples with block/frame position.
- Feeds the mixer datapath.

---
 rtl/spdif_subframe_assembler.sv | 278 +++++++++++++++++++++++++++
 tb/tb_spdif_subframe_assembler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spdif_subframe_assembler.sv
// S/PDIF subframe assembler: collects 28-bit subframes, checks parity, pairs left/right into stereo samples.
// Optional channel-status capture is built when SPDIF_ASM_CHSTAT_EN is defined.
module spdif_subframe_assembler #(
    parameter int SAMPLE_W         = 24,
    parameter int FRAMES_PER_BLOCK = 192
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pre_valid,
    input  logic [1:0]          pre_type,
    input  logic                bit_valid,
    input  logic                bit_data,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic [1:0]          vflags,
    output logic                parity_err,
    output logic                block_start,
    output logic [7:0]          frame_idx,
    output logic                sync_err,
    output logic [31:0]         cs_word,
    output logic                cs_valid
);

    typedef enum logic [1:0] {S_HUNT = 2'd0, S_COLLECT = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAMES_PER_BLOCK - 1);

    function automatic logic parity_step(input logic acc, input logic b);
        return acc ^ b;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          type_q, type_d;
    logic [27:0]         shift_q, shift_d;
    logic                par_q, par_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [SAMPLE_W-1:0] pl_sample_q, pl_sample_d;
    logic                pl_v_q, pl_v_d, pl_perr_q, pl_perr_d, pl_b_q, pl_b_d, pl_c_q, pl_c_d;
    logic                emit_q, emit_d;
    logic [SAMPLE_W-1:0] wr_sample_q, wr_sample_d;
    logic                wr_v_q, wr_v_d, wr_perr_q, wr_perr_d;
    logic                b_seen_q, b_seen_d;
    logic                sample_valid_q, sample_valid_d;
    logic [SAMPLE_W-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
    logic [1:0]          vflags_q, vflags_d;
    logic                parity_err_q, parity_err_d, block_start_q, block_start_d;
    logic [7:0]          frame_idx_q, frame_idx_d;
    logic                sync_err_q, sync_err_d;
    logic [7:0]          new_idx_s;
    logic                pre_ok_s;

    // Subframe FSM, left-pending store, and the registered output stage one cycle after DONE
    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        shift_d        = shift_q;
        par_d          = par_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        pl_sample_d    = pl_sample_q;
        pl_v_d         = pl_v_q;
        pl_perr_d      = pl_perr_q;
        pl_b_d         = pl_b_q;
        pl_c_d         = pl_c_q;
        emit_d         = 1'b0;
        wr_sample_d    = wr_sample_q;
        wr_v_d         = wr_v_q;
        wr_perr_d      = wr_perr_q;
        b_seen_d       = b_seen_q;
        sample_valid_d = 1'b0;
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
        vflags_d       = vflags_q;
        parity_err_d   = parity_err_q;
        block_start_d  = block_start_q;
        frame_idx_d    = frame_idx_q;
        sync_err_d     = 1'b0;
        pre_ok_s       = pre_valid && (pre_type != 2'b00);
        new_idx_s      = (pl_b_q || (frame_idx_q == LAST_IDX)) ? 8'd0 : frame_idx_q + 8'd1;

        case (state_q)
            S_HUNT: begin
                if (pre_ok_s) begin
                    type_d  = pre_type;
                    shift_d = 28'd0;
                    par_d   = 1'b0;
                    cnt_d   = 5'd0;
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_HUNT;
                end
            end
            S_COLLECT: begin
                if (pre_ok_s) begin
                    // A preamble inside a subframe means the previous one was short
                    type_d     = pre_type;
                    shift_d    = 28'd0;
                    par_d      = 1'b0;
                    cnt_d      = 5'd0;
                    sync_err_d = 1'b1;
                    state_d    = S_COLLECT;
                end else if (bit_valid) begin
                    shift_d = {bit_data, shift_q[27:1]};
                    par_d   = parity_step(par_q, bit_data);
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd27) ? S_DONE : S_COLLECT;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DONE: begin
                state_d = S_HUNT;
                if (type_q == 2'b11) begin
                    if (pend_q) begin
                        emit_d      = 1'b1;
                        wr_sample_d = shift_q[SAMPLE_W-1:0];
                        wr_v_d      = shift_q[SAMPLE_W];
                        wr_perr_d   = par_q;
                        pend_d      = 1'b0;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end else begin
                    sync_err_d  = pend_q;
                    pend_d      = 1'b1;
                    pl_sample_d = shift_q[SAMPLE_W-1:0];
                    pl_v_d      = shift_q[SAMPLE_W];
                    pl_c_d      = shift_q[SAMPLE_W+2];
                    pl_perr_d   = par_q;
                    pl_b_d      = (type_q == 2'b01);
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        if (emit_q) begin
            sample_valid_d = 1'b1;
            sample_l_d     = pl_sample_q;
            sample_r_d     = wr_sample_q;
            vflags_d       = {wr_v_q, pl_v_q};
            parity_err_d   = pl_perr_q | wr_perr_q;
            block_start_d  = pl_b_q;
            frame_idx_d    = new_idx_s;
            if (pl_b_q) begin
                // A B must follow the last frame of a block, except the very first one
                b_seen_d   = 1'b1;
                sync_err_d = sync_err_d | (b_seen_q && (frame_idx_q != LAST_IDX));
            end else begin
                b_seen_d = b_seen_q;
            end
        end else begin
            sample_valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_HUNT;
            type_q         <= 2'b00;
            shift_q        <= 28'd0;
            par_q          <= 1'b0;
            cnt_q          <= 5'd0;
            pend_q         <= 1'b0;
            pl_sample_q    <= '0;
            pl_v_q         <= 1'b0;
            pl_perr_q      <= 1'b0;
            pl_b_q         <= 1'b0;
            pl_c_q         <= 1'b0;
            emit_q         <= 1'b0;
            wr_sample_q    <= '0;
            wr_v_q         <= 1'b0;
            wr_perr_q      <= 1'b0;
            b_seen_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_l_q     <= '0;
            sample_r_q     <= '0;
            vflags_q       <= 2'b00;
            parity_err_q   <= 1'b0;
            block_start_q  <= 1'b0;
            frame_idx_q    <= 8'd0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            pl_sample_q    <= pl_sample_d;
            pl_v_q         <= pl_v_d;
            pl_perr_q      <= pl_perr_d;
            pl_b_q         <= pl_b_d;
            pl_c_q         <= pl_c_d;
            emit_q         <= emit_d;
            wr_sample_q    <= wr_sample_d;
            wr_v_q         <= wr_v_d;
            wr_perr_q      <= wr_perr_d;
            b_seen_q       <= b_seen_d;
            sample_valid_q <= sample_valid_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            vflags_q       <= vflags_d;
            parity_err_q   <= parity_err_d;
            block_start_q  <= block_start_d;
            frame_idx_q    <= frame_idx_d;
            sync_err_q     <= sync_err_d;
        end
    end

`ifdef SPDIF_ASM_CHSTAT_EN
    logic [31:0] shadow_q, shadow_d, shadow_base_s, cs_word_q, cs_word_d;
    logic        cs_valid_q, cs_valid_d;
    logic        unused_s;

    assign unused_s = ^{shift_q[SAMPLE_W+1], shift_q[27]};

    // Channel-status shadow: left C bit of frames 0..31, published when frame 31 is emitted
    always_comb begin
        shadow_d      = shadow_q;
        cs_word_d     = cs_word_q;
        cs_valid_d    = 1'b0;
        shadow_base_s = pl_b_q ? 32'd0 : shadow_q;
        if (emit_q) begin
            if (new_idx_s < 8'd32) begin
                shadow_base_s[new_idx_s[4:0]] = pl_c_q;
            end else begin
                shadow_base_s = shadow_base_s;
            end
            shadow_d = shadow_base_s;
            if (new_idx_s == 8'd31) begin
                cs_word_d  = shadow_base_s;
                cs_valid_d = 1'b1;
            end else begin
                cs_valid_d = 1'b0;
            end
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Channel-status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q   <= 32'd0;
            cs_word_q  <= 32'd0;
            cs_valid_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            cs_word_q  <= cs_word_d;
            cs_valid_q <= cs_valid_d;
        end
    end

    assign cs_word  = cs_word_q;
    assign cs_valid = cs_valid_q;
`else
    logic unused_s;

    assign unused_s = ^{shift_q[SAMPLE_W+1], shift_q[27], pl_c_q};
    assign cs_word  = 32'd0;
    assign cs_valid = 1'b0;
`endif

    assign sample_valid = sample_valid_q;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign vflags       = vflags_q;
    assign parity_err   = parity_err_q;
    assign block_start  = block_start_q;
    assign frame_idx    = frame_idx_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_spdif_subframe_assembler.sv
// Scoreboard bench for spdif_subframe_assembler: randomized subframes against a pair-level reference model.
module tb_spdif_subframe_assembler;
    localparam int FPB = 192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pre_valid = 1'b0;
    logic [1:0]  pre_type = 2'b00;
    logic        bit_valid = 1'b0;
    logic        bit_data = 1'b0;
    logic        sample_valid;
    logic [23:0] sample_l, sample_r;
    logic [1:0]  vflags;
    logic        parity_err, block_start, sync_err, cs_valid;
    logic [7:0]  frame_idx;
    logic [31:0] cs_word;

    spdif_subframe_assembler dut (
        .clk(clk), .rst(rst), .pre_valid(pre_valid), .pre_type(pre_type),
        .bit_valid(bit_valid), .bit_data(bit_data), .sample_valid(sample_valid),
        .sample_l(sample_l), .sample_r(sample_r), .vflags(vflags),
        .parity_err(parity_err), .block_start(block_start), .frame_idx(frame_idx),
        .sync_err(sync_err), .cs_word(cs_word), .cs_valid(cs_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] l, r;
        logic [1:0]  v;
        logic        perr, bs, csv;
        logic [7:0]  idx;
        logic [31:0] csw;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0, n_fail = 0;
    int          exp_sync = 0, got_sync = 0;
    bit          m_pend = 0, m_open = 0, m_bseen = 0;
    logic [23:0] m_l;
    logic        m_lv, m_lperr, m_lb, m_lc;
    int          m_idx = 0;
    logic [31:0] m_shadow = 32'd0;
    logic [31:0] cs_pat = 32'hA5A5F00F;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: applies pairing rules to one complete subframe
    task automatic model_done(input logic [1:0] t, input logic [27:0] w, input int edge_cyc);
        exp_t e;
        if (t != 2'b11) begin
            if (m_pend) exp_sync++;
            m_pend = 1; m_l = w[23:0]; m_lv = w[24]; m_lc = w[26]; m_lperr = ^w; m_lb = (t == 2'b01);
        end else if (!m_pend) begin
            exp_sync++;
        end else begin
            if (m_lb) begin
                if (m_bseen && m_idx != FPB - 1) exp_sync++;
                m_bseen = 1;
                m_idx = 0;
            end else begin
                m_idx = (m_idx + 1) % FPB;
            end
            e.l = m_l; e.r = w[23:0]; e.v = {w[24], m_lv}; e.perr = m_lperr | (^w);
            e.bs = m_lb; e.idx = 8'(m_idx); e.at = edge_cyc + 2; e.csv = 1'b0; e.csw = 32'd0;
`ifdef SPDIF_ASM_CHSTAT_EN
            if (m_lb) m_shadow = 32'd0;
            if (m_idx < 32) m_shadow[m_idx] = m_lc;
            if (m_idx == 31) begin e.csv = 1'b1; e.csw = m_shadow; end
`endif
            sb.push_back(e);
            m_pend = 0;
        end
    endtask

    task automatic step(input logic pv, input logic [1:0] pt, input logic bv, input logic bd);
        pre_valid = pv; pre_type = pt; bit_valid = bv; bit_data = bd;
        @(posedge clk); #1;
        pre_valid = 1'b0; bit_valid = 1'b0;
    endtask

    task automatic send_sf(input logic [1:0] t, input logic [23:0] s, input logic v,
                           input logic c, input logic flip, input int nbits);
        logic [27:0] w;
        int          last_edge;
        w = {1'b0, c, 1'($urandom_range(0, 1)), v, s};
        w[27] = (^w[26:0]) ^ flip;
        if (m_open) exp_sync++;
        step(1'b1, t, 1'b0, 1'b0);
        m_open = 1;
        last_edge = cyc;
        for (int i = 0; i < nbits; i++) begin
            int gap;
            gap = $urandom_range(0, 1);
            for (int g = 0; g < gap; g++) step(1'b0, 2'b00, 1'b0, 1'b0);
            step(1'b0, 2'b00, 1'b1, w[i]);
            last_edge = cyc;
        end
        if (nbits == 28) begin
            m_open = 0;
            step(1'b0, 2'b00, 1'b0, 1'b0);
            step(1'b0, 2'b00, 1'b0, 1'b0);
            model_done(t, w, last_edge);
        end
    endtask

    task automatic settle_sync(input string name);
        repeat (3) step(1'b0, 2'b00, 1'b0, 1'b0);
        check(name, 64'(got_sync), 64'(exp_sync));
    endtask

    function automatic logic cbit(input int f);
        logic [31:0] p;
        p = cs_pat;
        return (f < 32) ? p[f] : 1'($urandom_range(0, 1));
    endfunction

    // Monitor: pops the scoreboard on every sample_valid and counts sync_err pulses
    always @(negedge clk) begin
        exp_t e;
        if (rst && sync_err) got_sync++;
        if (rst && sample_valid) begin
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_sample: got sample_l %0h with empty scoreboard", sample_l);
            end else begin
                e = sb.pop_front();
                check("latency",     64'(cyc),         64'(e.at));
                check("sample_l",    64'(sample_l),    64'(e.l));
                check("sample_r",    64'(sample_r),    64'(e.r));
                check("vflags",      64'(vflags),      64'(e.v));
                check("parity_err",  64'(parity_err),  64'(e.perr));
                check("block_start", 64'(block_start), 64'(e.bs));
                check("frame_idx",   64'(frame_idx),   64'(e.idx));
                check("cs_valid",    64'(cs_valid),    64'(e.csv));
                if (e.csv) check("cs_word", 64'(cs_word), 64'(e.csw));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {sample_valid, sample_l, sample_r, vflags, parity_err,
                                block_start, frame_idx, sync_err, cs_valid}, 64'd0);
        check("reset_cs_word", 64'(cs_word), 64'd0);
        rst = 1'b1;
        step(1'b0, 2'b00, 1'b0, 1'b0);

        // Orphan W right after reset
        send_sf(2'b11, 24'(($urandom)), 1'b0, 1'b0, 1'b0, 28);
        settle_sync("sync_orphan_w");

        // Directed first pair, then the rest of a 192-frame block, then a new B
        send_sf(2'b01, 24'h123456, 1'b0, cbit(0), 1'b0, 28);
        send_sf(2'b11, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 28);
        for (int f = 1; f < FPB; f++) begin
            send_sf(2'b10, 24'(f), 1'($urandom_range(0, 1)), cbit(f), 1'b0, 28);
            send_sf(2'b11, 24'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 28);
        end
        send_sf(2'b01, 24'($urandom), 1'b0, 1'b1, 1'b0, 28);
        send_sf(2'b11, 24'($urandom), 1'b0, 1'b0, 1'b0, 28);
        settle_sync("sync_full_block");

        // Parity error on W, then a clean pair
        send_sf(2'b10, 24'($urandom), 1'b1, 1'b0, 1'b0, 28);
        send_sf(2'b11, 24'($urandom), 1'b0, 1'b0, 1'b1, 28);
        send_sf(2'b10, 24'($urandom), 1'b0, 1'b0, 1'b0, 28);
        send_sf(2'b11, 24'($urandom), 1'b1, 1'b0, 1'b0, 28);

        // Short M interrupted by a new M preamble
        send_sf(2'b10, 24'($urandom), 1'b0, 1'b0, 1'b0, 10);
        send_sf(2'b10, 24'h00C0DE, 1'b0, 1'b0, 1'b0, 28);
        send_sf(2'b11, 24'h0BEEF0, 1'b1, 1'b0, 1'b0, 28);
        settle_sync("sync_short_subframe");

        // Reset in the middle of a subframe
        send_sf(2'b10, 24'($urandom), 1'b0, 1'b0, 1'b0, 12);
        #2 rst = 1'b0;
        #1;
        check("midreset_outputs", {sample_valid, sample_l, sample_r, vflags, parity_err,
                                   block_start, frame_idx, sync_err, cs_valid}, 64'd0);
        check("midreset_cs_word", 64'(cs_word), 64'd0);
        check("midreset_scoreboard_empty", 64'(sb.size()), 64'd0);
        m_open = 0; m_pend = 0; m_idx = 0; m_bseen = 0; m_shadow = 32'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b0, 2'b00, 1'b0, 1'b0);

        send_sf(2'b01, 24'($urandom), 1'b1, 1'b1, 1'b0, 28);
        send_sf(2'b11, 24'($urandom), 1'b1, 1'b0, 1'b0, 28);
        settle_sync("sync_after_reset");

        for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, 2'b00, 1'b0, 1'b0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
